jpeg_byte_stuffer: RTL

//   Downstream of the Y-channel DCT/quantise/Huffman stage. Buffers its 32-bit JPEG_bitstream words (data_ready

---
 rtl/jpeg_pkg.sv | 39 +++
 rtl/jpeg_word_fifo.sv | 76 +++++++
 rtl/jpeg_byte_stuffer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_pkg
//   Shared types and constants for the JPEG byte stuffer and its word FIFO.
//   - stuff_state_e : serialiser FSM states
//   - fifo_entry_t  : one buffered word with its valid byte count and EOI flag
//   - word_byte()   : selects byte idx (0 = bits 31:24) of a 32-bit word
// -----------------------------------------------------------------------------
package jpeg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EMIT,
      STUFF,
      EOI_FF,
      EOI_D9
   } stuff_state_e;

   typedef struct packed {
      logic [31:0] word;
      logic [2:0]  nbytes;
      logic        eoi;
   } fifo_entry_t;

   localparam logic [7:0] BYTE_FF    = 8'hFF;
   localparam logic [7:0] BYTE_STUFF = 8'h00;
   localparam logic [7:0] EOI_LO     = 8'hD9;

   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/jpeg_word_fifo.sv
// -----------------------------------------------------------------------------
// jpeg_word_fifo
//   Synchronous FIFO of fifo_entry_t. Read data is the head entry, valid while
//   empty_o is low. A push while full is accepted only when a pop happens in
//   the same cycle (the freed slot is the one being written).
// Ports
//   clk         clock
//   rst         asynchronous active-low reset (pointers and count only)
//   push_i      write request
//   push_data_i entry to write
//   pop_i       read request (ignored when empty)
//   pop_data_o  head entry
//   full_o      count == FIFO_DEPTH
//   empty_o     count == 0
// -----------------------------------------------------------------------------
module jpeg_word_fifo
   import jpeg_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  fifo_entry_t push_data_i,
   input  logic        pop_i,
   output fifo_entry_t pop_data_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   fifo_entry_t   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_en, rd_en;

   assign full_o     = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty_o    = (count_q == '0);
   assign rd_en      = pop_i & ~empty_o;
   assign wr_en      = push_i & (~full_o | rd_en);
   assign pop_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are AW bits wide, so they wrap mod FIFO_DEPTH on their own.
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries data only; emptiness is tracked by count_q.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// -----------------------------------------------------------------------------
// jpeg_byte_stuffer
//   Buffers 32-bit Huffman words and serialises them MSB byte first onto a
//   valid/ready byte stream, inserting 0x00 after every 0xFF data byte and
//   appending the FF D9 end-of-image marker after a flush.
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   word_in     32-bit Huffman word, bit 31 first
//   word_valid  one-cycle push strobe
//   flush       end of image; word_in carries a partial word if flush_bits != 0
//   flush_bits  number of valid MSBs of word_in at flush
//   byte_out    output byte
//   byte_valid  byte_out valid, held until accepted
//   byte_ready  downstream accept
//   overflow    sticky: a push was dropped because the FIFO was full
//   busy        FIFO non-empty or serialiser active
//   eoi_done    one-cycle pulse while the D9 byte is accepted
// -----------------------------------------------------------------------------
module jpeg_byte_stuffer
   import jpeg_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   input  logic        flush,
   input  logic [4:0]  flush_bits,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        overflow,
   output logic        busy,
   output logic        eoi_done
);

   stuff_state_e state_q, state_d;
   fifo_entry_t  cur_q, cur_d;
   logic [1:0]   idx_q, idx_d;
   logic [7:0]   byte_out_q, byte_out_d;
   logic         byte_valid_q, byte_valid_d;
   logic         overflow_q, overflow_d;

   fifo_entry_t  push_entry;
   fifo_entry_t  fifo_head;
   logic         push_any, fifo_pop, fifo_full, fifo_empty;
   logic         xfer, advance, load_next;

   assign push_any = word_valid | flush;

   // A flush entry keeps only the valid MSBs and pads the rest with ones, so
   // the last partial byte is completed the way JPEG requires.
   always_comb begin
      push_entry.word   = word_in;
      push_entry.nbytes = 3'd4;
      push_entry.eoi    = 1'b0;
      if (flush) begin
         push_entry.word   = word_in | (32'hFFFF_FFFF >> flush_bits);
         push_entry.nbytes = 3'(({1'b0, flush_bits} + 6'd7) >> 3);
         push_entry.eoi    = 1'b1;
      end
   end

   jpeg_word_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_any),
      .push_data_i (push_entry),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign xfer       = byte_valid_q & byte_ready;
   assign overflow_d = overflow_q | (push_any & fifo_full & ~fifo_pop);

   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      idx_d        = idx_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = byte_valid_q;
      fifo_pop     = 1'b0;
      advance      = 1'b0;
      load_next    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) load_next = 1'b1;
         end
         EMIT: begin
            if (xfer) begin
               if (byte_out_q == BYTE_FF) begin
                  state_d    = STUFF;
                  byte_out_d = BYTE_STUFF;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         STUFF: begin
            if (xfer) advance = 1'b1;
         end
         EOI_FF: begin
            if (xfer) begin
               state_d    = EOI_D9;
               byte_out_d = EOI_LO;
            end
         end
         EOI_D9: begin
            if (xfer) begin
               state_d      = IDLE;
               byte_valid_d = 1'b0;
            end
         end
         default: begin
            state_d      = IDLE;
            byte_valid_d = 1'b0;
         end
      endcase

      // Move past a completed data byte: next byte, EOI, next entry or idle.
      if (advance) begin
         if (({1'b0, idx_q} + 3'd1) < cur_q.nbytes) begin
            idx_d      = idx_q + 2'd1;
            state_d    = EMIT;
            byte_out_d = word_byte(cur_q.word, idx_q + 2'd1);
         end else if (cur_q.eoi) begin
            state_d    = EOI_FF;
            byte_out_d = BYTE_FF;
         end else if (!fifo_empty) begin
            load_next = 1'b1;
         end else begin
            state_d      = IDLE;
            byte_valid_d = 1'b0;
         end
      end

      // Popping straight from EMIT/STUFF keeps the stream bubble-free.
      if (load_next) begin
         fifo_pop = 1'b1;
         cur_d    = fifo_head;
         idx_d    = 2'd0;
         if (fifo_head.nbytes != 3'd0) begin
            state_d      = EMIT;
            byte_out_d   = fifo_head.word[31:24];
            byte_valid_d = 1'b1;
         end else if (fifo_head.eoi) begin
            state_d      = EOI_FF;
            byte_out_d   = BYTE_FF;
            byte_valid_d = 1'b1;
         end else begin
            state_d      = IDLE;
            byte_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         byte_out_q   <= 8'h00;
         byte_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         overflow_q   <= overflow_d;
      end
   end

   // The current entry is only meaningful outside IDLE, so it needs no reset.
   always_ff @(posedge clk) begin
      cur_q <= cur_d;
   end

   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign overflow   = overflow_q;
   assign busy       = ~fifo_empty | (state_q != IDLE);
   assign eoi_done   = (state_q == EOI_D9) & byte_ready;

endmodule
